// File: rtl/booth_divider.sv
// Sequential signed divider: 2W-bit dividend / W-bit divisor -> W-bit quotient and remainder.
// Restoring shift-subtract on magnitudes, one quotient bit per clock, sign fix-up at the end.
module booth_divider #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend_hi,
  input  logic [WIDTH-1:0] dividend_lo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int unsigned DW = 2 * WIDTH;
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] ONE_W  = WIDTH'(1);
  localparam logic [DW-1:0]    ONE_DW = DW'(1);
  localparam logic [WIDTH-1:0] HALF   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CW-1:0]    LAST   = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PREP,
    S_RUN,
    S_FIX
  } state_t;

  state_t           state_q, state_d;
  logic [DW-1:0]    n_q, n_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sq_q, sq_d;
  logic             sr_q, sr_d;
  logic [WIDTH-1:0] quotient_d, remainder_d;
  logic             busy_d, done_d, div_by_zero_d, overflow_d;

  logic [DW-1:0]    n_mag;
  logic [WIDTH-1:0] d_mag;
  logic [WIDTH:0]   trial, trial_sub;
  logic             trial_ge;

  // Magnitudes of the captured operands; the most negative value maps onto itself as unsigned.
  assign n_mag     = n_q[DW-1]    ? (~n_q + ONE_DW) : n_q;
  assign d_mag     = d_q[WIDTH-1] ? (~d_q + ONE_W)  : d_q;
  assign trial     = {rem_q, shreg_q[WIDTH-1]};
  assign trial_sub = trial - {1'b0, d_mag};
  assign trial_ge  = (trial >= {1'b0, d_mag});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      n_q         <= '0;
      d_q         <= '0;
      rem_q       <= '0;
      shreg_q     <= '0;
      cnt_q       <= '0;
      sq_q        <= 1'b0;
      sr_q        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      d_q         <= d_d;
      rem_q       <= rem_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      sq_q        <= sq_d;
      sr_q        <= sr_d;
      quotient    <= quotient_d;
      remainder   <= remainder_d;
      busy        <= busy_d;
      done        <= done_d;
      div_by_zero <= div_by_zero_d;
      overflow    <= overflow_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    n_d           = n_q;
    d_d           = d_q;
    rem_d         = rem_q;
    shreg_d       = shreg_q;
    cnt_d         = cnt_q;
    sq_d          = sq_q;
    sr_d          = sr_q;
    quotient_d    = quotient;
    remainder_d   = remainder;
    done_d        = 1'b0;
    div_by_zero_d = div_by_zero;
    overflow_d    = overflow;

    case (state_q)
      S_IDLE: begin
        // The cycle carrying done is not a load opportunity.
        if (start && !done) begin
          n_d           = {dividend_hi, dividend_lo};
          d_d           = divisor;
          div_by_zero_d = 1'b0;
          overflow_d    = 1'b0;
          state_d       = S_PREP;
        end
      end
      S_PREP: begin
        sq_d = n_q[DW-1] ^ d_q[WIDTH-1];
        sr_d = n_q[DW-1];
        if (d_q == '0) begin
          div_by_zero_d = 1'b1;
          state_d       = S_FIX;
        end else if (n_mag[DW-1:WIDTH] >= d_mag) begin
          overflow_d = 1'b1;
          state_d    = S_FIX;
        end else begin
          rem_d   = n_mag[DW-1:WIDTH];
          shreg_d = n_mag[WIDTH-1:0];
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        rem_d   = trial_ge ? trial_sub[WIDTH-1:0] : trial[WIDTH-1:0];
        shreg_d = {shreg_q[WIDTH-2:0], trial_ge};
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) state_d = S_FIX;
      end
      S_FIX: begin
        quotient_d  = '0;
        remainder_d = '0;
        if (!div_by_zero && !overflow) begin
          // Negative results may reach -2^(W-1); positive ones stop at 2^(W-1)-1.
          if (sq_q ? (shreg_q > HALF) : (shreg_q >= HALF)) begin
            overflow_d = 1'b1;
          end else begin
            quotient_d  = sq_q ? (~shreg_q + ONE_W) : shreg_q;
            remainder_d = sr_q ? (~rem_q + ONE_W)   : rem_q;
          end
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

endmodule

// File: tb/tb_booth_divider.sv
// Scoreboard bench for booth_divider: random and directed ops against an integer-division model.
module tb_booth_divider;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend_hi, dividend_lo, divisor;
  logic [W-1:0] quotient, remainder;
  logic         busy, done, div_by_zero, overflow;

  booth_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .dividend_hi(dividend_hi), .dividend_lo(dividend_lo), .divisor(divisor),
    .quotient(quotient), .remainder(remainder),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    bit           dbz;
    bit           ovf;
    int           lat;
    int           e0;
    string        tag;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain signed integer division, truncating toward zero.
  function automatic exp_t model(input logic [2*W-1:0] n, input logic [W-1:0] d, input string tag);
    exp_t e;
    int ni, di, q, r, an, ad;
    ni = int'($signed(n));
    di = int'($signed(d));
    e.tag = tag; e.q = '0; e.r = '0; e.dbz = 0; e.ovf = 0; e.e0 = 0;
    if (di == 0) begin
      e.dbz = 1; e.lat = 2;
    end else begin
      q  = ni / di;
      r  = ni % di;
      an = (ni < 0) ? -ni : ni;
      ad = (di < 0) ? -di : di;
      e.lat = (an >= ad * (1 << W)) ? 2 : W + 2;
      if (q > (1 << (W-1)) - 1 || q < -(1 << (W-1))) e.ovf = 1;
      else begin
        e.q = W'(q);
        e.r = W'(r);
      end
    end
    return e;
  endfunction

  // Monitor: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.tag, "_quotient"}, int'(quotient), int'(e.q));
        check({e.tag, "_remainder"}, int'(remainder), int'(e.r));
        check({e.tag, "_div_by_zero"}, int'(div_by_zero), int'(e.dbz));
        check({e.tag, "_overflow"}, int'(overflow), int'(e.ovf));
        check({e.tag, "_latency"}, cyc - e.e0, e.lat);
        check({e.tag, "_busy_low"}, int'(busy), 0);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((busy || done) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) check("wait_idle_timeout", 1, 0);
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check({tag, "_done_timeout"}, int'(sb.size()), 0);
      sb.delete();
    end
  endtask

  // Issue one op; inputs are scrambled while busy to show they are not resampled.
  task automatic run_op(input logic [2*W-1:0] n, input logic [W-1:0] d, input string tag);
    exp_t e;
    wait_idle();
    {dividend_hi, dividend_lo} = n;
    divisor = d;
    start = 1'b1;
    e = model(n, d, tag);
    @(posedge clk);
    #1;
    e.e0 = cyc;
    sb.push_back(e);
    start = 1'b0;
    dividend_hi = W'($urandom);
    dividend_lo = W'($urandom);
    divisor = W'($urandom);
    wait_drain(tag);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_quotient"}, int'(quotient), 0);
    check({tag, "_remainder"}, int'(remainder), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_div_by_zero"}, int'(div_by_zero), 0);
    check({tag, "_overflow"}, int'(overflow), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0]   a, b;
    logic [2*W-1:0] p;
    exp_t e;
    int   n;

    rst_n = 1'b0; start = 1'b0;
    dividend_hi = '0; dividend_lo = '0; divisor = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Directed cases
    run_op(16'h0064, 8'h07, "pos_div");
    run_op(16'hFF9C, 8'h07, "negn_posd");
    run_op(16'hFF9C, 8'hF9, "negn_negd");
    run_op(16'hF857, 8'h35, "roundtrip_fixed");
    run_op(16'hFF00, 8'h02, "min_quot");
    run_op(16'h0100, 8'h02, "ovf_fix");
    run_op(16'h4000, 8'h02, "ovf_prep");
    run_op(16'h1234, 8'h00, "div_zero");
    run_op(16'h0064, 8'h07, "after_dbz");
    run_op(16'h8000, 8'h80, "most_neg");
    run_op(16'hFF80, 8'hFF, "neg128_by_m1");

    // Round trip against products of the multiplier's operand pairs
    for (int i = 0; i < 24; i++) begin
      a = W'($urandom);
      do b = W'($urandom); while (b == '0);
      p = 16'($signed(a) * $signed(b));
      e = model(p, b, "rt");
      check("rt_model_recovers_factor", int'(e.q), int'(a));
      run_op(p, b, "roundtrip");
    end

    // Unconstrained random operands, including zero divisors and overflows
    for (int i = 0; i < 24; i++) begin
      p = 16'($urandom);
      if (i % 3 == 0) p = 16'($signed(p[9:0]));
      b = (i % 7 == 0) ? 8'h00 : W'($urandom);
      run_op(p, b, "random");
    end

    // start held high through an op and across the done cycle: exactly one result
    wait_idle();
    {dividend_hi, dividend_lo} = 16'h0200;
    divisor = 8'h09;
    start = 1'b1;
    e = model(16'h0200, 8'h09, "held_start");
    @(posedge clk);
    #1;
    e.e0 = cyc;
    sb.push_back(e);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 40);
    if (n >= 40) check("held_start_timeout", 1, 0);
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (16) @(negedge clk);
    check("held_start_one_done", int'(sb.size()), 0);
    sb.delete();

    // Reset in the middle of RUN aborts with no done
    wait_idle();
    {dividend_hi, dividend_lo} = 16'h0064;
    divisor = 8'h07;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_all_zero("mid_reset");
    rst_n = 1'b1;
    repeat (14) @(negedge clk);
    check("mid_reset_no_done", int'(done), 0);

    run_op(16'hFF9C, 8'h07, "after_reset");
    run_op(16'h7FFF, 8'h7F, "max_by_max");

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/booth_divider.md
Name: booth_divider

Overview:
- Sequential signed divider: 2W-bit two's-complement dividend by W-bit two's-complement divisor, giving a W-bit quotient and a W-bit remainder.
- Inverse of the team's Booth multiplier. Its dividend ports take the multiplier's high/low product halves directly, so a product divided by either factor recovers the other factor.
- Shift-subtract (restoring) core on magnitudes, one quotient bit per clock, with sign fix-up at the end.

Parameters:
- WIDTH, 8, operand width W. Dividend is 2W bits; quotient and remainder are W bits each.

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst_n  input  1  synchronous active-low reset, sampled on rising clk
- start  input  1  load strobe; sampled only in IDLE
- dividend_hi  input  WIDTH  dividend bits [2W-1:W] (multiplier high half)
- dividend_lo  input  WIDTH  dividend bits [W-1:0] (multiplier low half)
- divisor  input  WIDTH  signed divisor
- quotient  output  WIDTH  signed quotient, truncated toward zero
- remainder  output  WIDTH  signed remainder; sign follows dividend
- busy  output  1  high in every non-IDLE state
- done  output  1  one-cycle pulse when results are valid
- div_by_zero  output  1  divisor was 0 for the last completed operation
- overflow  output  1  quotient not representable in W signed bits

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE; quotient, remainder, busy, done, div_by_zero, overflow all 0.
- Reset mid-operation aborts immediately. There is no partial result and no done pulse.
- States: IDLE -> PREP -> RUN -> FIX -> IDLE.
- IDLE, start=1: capture dividend {hi,lo} and divisor; clear both flags; go to PREP.
- PREP:
  - Compute magnitudes |N| (2W bits, unsigned; 16'h8000 -> 16'h8000) and |D| (W bits, unsigned).
  - Record result signs: sq = sign(N) xor sign(D); sr = sign(N).
  - If divisor==0: div_by_zero=1, go to FIX.
  - Else if |N|[2W-1:W] >= |D|: overflow=1, go to FIX.
  - Else load partial remainder = |N|[2W-1:W], shift register = |N|[W-1:0], counter=0; go to RUN.
- RUN: one iteration per cycle, exactly W cycles.
  - Shift {rem, shreg} left 1 into a W+1-bit trial.
  - If trial >= |D|: subtract |D| and shift in quotient bit 1; else shift in 0.
  - After counter reaches W-1, go to FIX.
- FIX:
  - If no flag yet: magnitude quotient q_mag > 2^(W-1)-1 with sq=0, or q_mag > 2^(W-1) with sq=1, sets overflow=1.
  - If no flag: quotient = sq ? -q_mag : q_mag; remainder = sr ? -r_mag : r_mag.
  - If any flag set: quotient=0, remainder=0.
  - Register results, assert done=1, go to IDLE.
- Latency from start-sampling edge E0:
  - Normal: done high in the cycle after edge E0+W+2 (W=8: 10 edges).
  - Error paths: done high after edge E0+2.
- done is high exactly one cycle; busy falls in the same cycle done rises.
- quotient, remainder and flags hold until the next FIX or reset.
- start while busy is ignored, with no queuing. start in the same cycle as done is not sampled; the next start is accepted in the following IDLE cycle.
- Inputs are sampled only at E0. Changing them during busy has no effect.

Test Plan:
- dividend 16'h0064 (100), divisor 8'h07 -> quotient 8'h0E (14), remainder 8'h02; done exactly 10 edges after start; flags 0.
- dividend 16'hFF9C (-100), divisor 8'h07 -> quotient 8'hF2 (-14), remainder 8'hFE (-2). Same dividend with divisor 8'hF9 (-7) -> quotient 8'h0E, remainder 8'hFE.
- Round trip with multiplier: dividend 16'hF857 (-37*53), divisor 8'h35 (53) -> quotient 8'hDB (-37), remainder 8'h00. Repeat over a random sweep of inp1/inp2 pairs with nonzero divisor; quotient must equal inp1.
- Range boundaries:
  - 16'hFF00 / 8'h02 -> quotient 8'h80, overflow=0.
  - 16'h0100 / 8'h02 -> overflow=1 (from FIX), quotient 0.
  - 16'h4000 / 8'h02 -> overflow=1 (from PREP), done 2 edges after start.
- divisor 8'h00 with any dividend -> div_by_zero=1, quotient=remainder=0, done 2 edges after start. A following valid op clears the flag.
- Control:
  - start held high through an operation -> exactly one done per accepted start.
  - rst_n=0 at iteration 4 -> next cycle all outputs 0, busy 0, no done.
  - New start after reset computes correctly.
